// File: rtl/cluster_pkg.sv
// -----------------------------------------------------------------------------
// cluster_pkg
// Shared constants, the cluster word layout and field-extract helpers used by
// the cluster unpacker and its expander.
//   Cluster word: {cnt[13:11], adr[10:0]}, cnt = cluster size - 1.
//   Any adr >= NUM_SBITS (idle marker 0x7FF included) marks an empty slot.
// -----------------------------------------------------------------------------
package cluster_pkg;

  localparam int CLUSTER_WIDTH      = 14;
  localparam int ADR_WIDTH          = 11;
  localparam int CNT_WIDTH          = 3;
  localparam int NUM_SBITS          = 1536;
  localparam int NUM_VFATS          = 24;
  localparam int SBITS_PER_VFAT     = 64;
  localparam int NUM_CLUSTERS       = 8;
  localparam int CLUSTERS_PER_CYCLE = 2;
  localparam int RUN_WIDTH          = 8;   // longest cluster: 2**CNT_WIDTH bits

  localparam logic [ADR_WIDTH-1:0] INVALID_ADR = 11'h7FF;
  localparam logic [ADR_WIDTH-1:0] MAX_ADR     = 11'd1535;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] cnt;
    logic [ADR_WIDTH-1:0] adr;
  } cluster_t;

  // Start address of the cluster.
  function automatic logic [ADR_WIDTH-1:0] cluster_adr(input logic [CLUSTER_WIDTH-1:0] word);
    cluster_t c;
    c = cluster_t'(word);
    return c.adr;
  endfunction

  // Cluster size minus one.
  function automatic logic [CNT_WIDTH-1:0] cluster_cnt(input logic [CLUSTER_WIDTH-1:0] word);
    cluster_t c;
    c = cluster_t'(word);
    return c.cnt;
  endfunction

  // A slot carries a cluster only when its address lies inside the hit map.
  function automatic logic adr_is_valid(input logic [ADR_WIDTH-1:0] adr);
    return (adr <= MAX_ADR);
  endfunction

endpackage

// File: rtl/cluster_expander.sv
// -----------------------------------------------------------------------------
// cluster_expander
// Combinational expansion of one cluster word into a full-width hit mask.
// Bits adr .. adr+cnt are set; bits past the top of the map are dropped
// (clipped, never wrapped). Empty slots give an all-zero mask.
// Ports:
//   cluster  in  14    {cnt, adr}
//   mask     out 1536  expanded hit mask
//   valid    out 1     slot holds a real cluster
// -----------------------------------------------------------------------------
module cluster_expander
  import cluster_pkg::*;
(
  input  logic [CLUSTER_WIDTH-1:0] cluster,
  output logic [NUM_SBITS-1:0]     mask,
  output logic                     valid
);

  logic [ADR_WIDTH-1:0] adr_s;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic [RUN_WIDTH-1:0] run_s;

  // Build a run of cnt+1 ones and shift it to adr; the left shift inside a
  // NUM_SBITS-wide vector discards anything beyond bit 1535.
  always_comb begin
    adr_s = cluster_adr(cluster);
    cnt_s = cluster_cnt(cluster);
    valid = adr_is_valid(adr_s);
    run_s = 8'hFF >> (3'd7 - cnt_s);
    if (valid) begin
      mask = {{(NUM_SBITS-RUN_WIDTH){1'b0}}, run_s} << adr_s;
    end else begin
      mask = {NUM_SBITS{1'b0}};
    end
  end

endmodule

// File: rtl/cluster_unpacker.sv
// -----------------------------------------------------------------------------
// cluster_unpacker
// Rebuilds the 1536-bit VFAT3 s-bit hit map from the eight cluster words of a
// bunch crossing, two clusters per clock4x cycle, four cycles per crossing.
// Optional feature macro: CLUSTER_UNPACKER_VFAT_OR_EN adds the per-VFAT OR
// output vfat_or.
// Ports:
//   clock4x         in  1     160 MHz clock, rising edge
//   global_reset    in  1     synchronous, active-high
//   clusters_valid  in  1     strobe: cluster0..7 valid this cycle
//   cluster0..7     in  14    {cnt, adr} cluster words
//   sbits           out 1536  reconstructed hit map, held until next update
//   sbits_valid     out 1     one-cycle pulse when sbits updates
//   cluster_count   out 4     valid clusters in the crossing just output
//   busy            out 1     expansion in phases 0..2, strobes are dropped
//   overflow        out 1     sticky: a strobe arrived while busy
//   vfat_or         out 24    (macro only) OR of each 64-bit VFAT slice
// -----------------------------------------------------------------------------
module cluster_unpacker
  import cluster_pkg::*;
(
  input  logic                     clock4x,
  input  logic                     global_reset,
  input  logic                     clusters_valid,
  input  logic [CLUSTER_WIDTH-1:0] cluster0,
  input  logic [CLUSTER_WIDTH-1:0] cluster1,
  input  logic [CLUSTER_WIDTH-1:0] cluster2,
  input  logic [CLUSTER_WIDTH-1:0] cluster3,
  input  logic [CLUSTER_WIDTH-1:0] cluster4,
  input  logic [CLUSTER_WIDTH-1:0] cluster5,
  input  logic [CLUSTER_WIDTH-1:0] cluster6,
  input  logic [CLUSTER_WIDTH-1:0] cluster7,
  output logic [NUM_SBITS-1:0]     sbits,
  output logic                     sbits_valid,
  output logic [3:0]               cluster_count,
  output logic                     busy,
  output logic                     overflow
`ifdef CLUSTER_UNPACKER_VFAT_OR_EN
  ,
  output logic [NUM_VFATS-1:0]     vfat_or
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;
  localparam logic [1:0] PHASE_LAST = 2'd3;

  logic [CLUSTER_WIDTH-1:0] in_words_s [NUM_CLUSTERS];
  logic [CLUSTER_WIDTH-1:0] words_r    [NUM_CLUSTERS];

  logic [0:0]           state_r;
  logic [1:0]           phase_r;
  logic [NUM_SBITS-1:0] work_r;
  logic [3:0]           count_r;

  logic [NUM_SBITS-1:0] sbits_r;
  logic                 sbits_valid_r;
  logic [3:0]           cluster_count_r;
  logic                 busy_r;
  logic                 overflow_r;

  logic [CLUSTER_WIDTH-1:0] op_a_s;
  logic [CLUSTER_WIDTH-1:0] op_b_s;
  logic [NUM_SBITS-1:0]     mask_a_s;
  logic [NUM_SBITS-1:0]     mask_b_s;
  logic                     valid_a_s;
  logic                     valid_b_s;
  logic [NUM_SBITS-1:0]     final_s;
  logic [3:0]               count_next_s;

  assign in_words_s[0] = cluster0;
  assign in_words_s[1] = cluster1;
  assign in_words_s[2] = cluster2;
  assign in_words_s[3] = cluster3;
  assign in_words_s[4] = cluster4;
  assign in_words_s[5] = cluster5;
  assign in_words_s[6] = cluster6;
  assign in_words_s[7] = cluster7;

  // Select the cluster pair belonging to the current phase.
  always_comb begin
    case (phase_r)
      2'd0: begin
        op_a_s = words_r[0];
        op_b_s = words_r[1];
      end
      2'd1: begin
        op_a_s = words_r[2];
        op_b_s = words_r[3];
      end
      2'd2: begin
        op_a_s = words_r[4];
        op_b_s = words_r[5];
      end
      2'd3: begin
        op_a_s = words_r[6];
        op_b_s = words_r[7];
      end
      default: begin
        op_a_s = {CLUSTER_WIDTH{1'b1}};
        op_b_s = {CLUSTER_WIDTH{1'b1}};
      end
    endcase
  end

  cluster_expander u_expander_a (
    .cluster (op_a_s),
    .mask    (mask_a_s),
    .valid   (valid_a_s)
  );

  cluster_expander u_expander_b (
    .cluster (op_b_s),
    .mask    (mask_b_s),
    .valid   (valid_b_s)
  );

  // Working map and count after merging the current pair; max count is 8.
  always_comb begin
    final_s      = work_r | mask_a_s | mask_b_s;
    count_next_s = count_r + {3'b000, valid_a_s} + {3'b000, valid_b_s};
  end

`ifdef CLUSTER_UNPACKER_VFAT_OR_EN
  logic [NUM_VFATS-1:0] vfat_or_s;
  logic [NUM_VFATS-1:0] vfat_or_r;

  // Per-VFAT OR of the map that is about to be published.
  always_comb begin
    for (int v = 0; v < NUM_VFATS; v++) begin
      vfat_or_s[v] = |final_s[v*SBITS_PER_VFAT +: SBITS_PER_VFAT];
    end
  end

  // vfat_or follows sbits on the same edge.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      vfat_or_r <= {NUM_VFATS{1'b0}};
    end else if ((state_r == ST_EXPAND) && (phase_r == PHASE_LAST)) begin
      vfat_or_r <= vfat_or_s;
    end else begin
      vfat_or_r <= vfat_or_r;
    end
  end

  assign vfat_or = vfat_or_r;
`endif

  // Word latch for a new crossing; only taken when the FSM can accept it.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        words_r[i] <= {3'b000, INVALID_ADR};
      end
    end else if (clusters_valid &&
                 ((state_r == ST_IDLE) || (phase_r == PHASE_LAST))) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        words_r[i] <= in_words_s[i];
      end
    end else begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        words_r[i] <= words_r[i];
      end
    end
  end

  // Expansion FSM: one pair per phase, publish on phase 3, optionally restart
  // back-to-back when the next strobe coincides with the publishing edge.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state_r         <= ST_IDLE;
      phase_r         <= 2'd0;
      work_r          <= {NUM_SBITS{1'b0}};
      count_r         <= 4'd0;
      sbits_r         <= {NUM_SBITS{1'b0}};
      sbits_valid_r   <= 1'b0;
      cluster_count_r <= 4'd0;
      busy_r          <= 1'b0;
      overflow_r      <= 1'b0;
    end else begin
      sbits_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (clusters_valid) begin
            state_r <= ST_EXPAND;
            phase_r <= 2'd0;
            work_r  <= {NUM_SBITS{1'b0}};
            count_r <= 4'd0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (phase_r == PHASE_LAST) begin
            sbits_r         <= final_s;
            cluster_count_r <= count_next_s;
            sbits_valid_r   <= 1'b1;
            work_r          <= {NUM_SBITS{1'b0}};
            count_r         <= 4'd0;
            phase_r         <= 2'd0;
            if (clusters_valid) begin
              state_r <= ST_EXPAND;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            work_r  <= final_s;
            count_r <= count_next_s;
            phase_r <= phase_r + 2'd1;
            // Entering phase 3 is the first cycle a new strobe is accepted.
            busy_r  <= (phase_r != 2'd2);
            if (clusters_valid) begin
              overflow_r <= 1'b1;
            end else begin
              overflow_r <= overflow_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          phase_r <= 2'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sbits         = sbits_r;
  assign sbits_valid   = sbits_valid_r;
  assign cluster_count = cluster_count_r;
  assign busy          = busy_r;
  assign overflow      = overflow_r;

endmodule
